// File: rtl/moore_rle_pkg.sv
// Shared types for the Moore-code run-length encoder.
// Records are packed {code, run}; REC_W is the width for the default run counter.
package moore_rle_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rle_state_t;

    typedef logic [1:0] code_t;

    localparam int RUN_W_DEF = 6;
    localparam int REC_W     = 2 + RUN_W_DEF;

    function automatic int rec_width(input int run_w);
        return 2 + run_w;
    endfunction

endpackage

// File: rtl/moore_rle_fifo.sv
// Record FIFO with a registered head; a push into a full FIFO is accepted only
// when a pop happens on the same edge. Latency: pushed data visible the next cycle.
module moore_rle_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [AW:0]   level_q, level_d, level_after_pop;
    logic [W-1:0]  head_q, head_d;
    logic          pop_eff, push_eff;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (AW+1)'(DEPTH));
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    always_comb begin
        rd_ptr_nxt      = rd_ptr_q + AW'(pop_eff);
        level_after_pop = level_q - (AW+1)'(pop_eff);
        level_d         = level_after_pop + (AW+1)'(push_eff);
        head_d          = '0;
        // Head must reflect the post-edge state: the pushed word if the FIFO drains to it.
        if (level_d != '0) begin
            if (level_after_pop == '0) begin
                head_d = push_dat;
            end else begin
                head_d = mem_q[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_eff);
            rd_ptr_q <= rd_ptr_nxt;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign head_dat = head_q;
    assign level    = level_q;

endmodule

// File: rtl/moore_code_rle.sv
// Run-length encoder for 2-bit Moore codes; closed runs go into a record FIFO.
// Record visible one cycle after its trigger; full FIFO without a pop drops it (sticky overflow).
module moore_code_rle
    import moore_rle_pkg::*;
#(
    parameter int RUN_W = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               code_in,
    input  logic                     code_en,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_code,
    output logic [RUN_W-1:0]         out_run,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int REC_BITS = 2 + RUN_W;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    rle_state_t        state_q, state_d;
    code_t             cur_code_q, cur_code_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              overflow_q, overflow_d;
    logic              emit, pop, fifo_full, fifo_empty;
    logic [REC_BITS-1:0] emit_rec, head_rec;

    // Every emit closes the currently open run, so the record is always the run registers.
    assign emit_rec = {cur_code_q, run_cnt_q};

    always_comb begin
        state_d    = state_q;
        cur_code_d = cur_code_q;
        run_cnt_d  = run_cnt_q;
        emit       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (code_en) begin
                    state_d    = RUN;
                    cur_code_d = code_in;
                    run_cnt_d  = RUN_W'(1);
                end
            end
            RUN: begin
                if (flush) begin
                    emit = 1'b1;
                    if (code_en) begin
                        cur_code_d = code_in;
                        run_cnt_d  = RUN_W'(1);
                    end else begin
                        state_d   = IDLE;
                        run_cnt_d = '0;
                    end
                end else if (code_en) begin
                    if (code_in == cur_code_q) begin
                        if (run_cnt_q == RUN_MAX) begin
                            emit      = 1'b1;
                            run_cnt_d = RUN_W'(1);
                        end else begin
                            run_cnt_d = run_cnt_q + RUN_W'(1);
                        end
                    end else begin
                        emit       = 1'b1;
                        cur_code_d = code_in;
                        run_cnt_d  = RUN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop        = out_valid && out_ready;
    assign overflow_d = overflow_q || (emit && fifo_full && !pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_code_q <= '0;
            run_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_code_q <= cur_code_d;
            run_cnt_q  <= run_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    moore_rle_fifo #(
        .W     (REC_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (emit),
        .push_dat (emit_rec),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_rec),
        .level    (level)
    );

    assign out_valid = !fifo_empty;
    assign out_code  = head_rec[REC_BITS-1 -: 2];
    assign out_run   = head_rec[RUN_W-1:0];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_moore_code_rle.sv
// Bench for moore_code_rle: table vectors, directed corner sequences and random traffic
// against a queue-based reference model.
module tb_moore_code_rle;

    localparam int RW    = 6;
    localparam int DEPTH = 4;
    localparam int RMAX  = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          reset, code_en, flush, out_ready;
    logic [1:0]    code_in;
    logic          out_valid, overflow;
    logic [1:0]    out_code;
    logic [RW-1:0] out_run;
    logic [2:0]    level;

    int tests = 0;
    int fails = 0;

    // Reference model: open run as plain integers, FIFO as a queue of records.
    bit       m_open;
    int       m_code, m_cnt;
    bit       m_ovf;
    bit [7:0] mq[$];
    bit [7:0] got[$];

    typedef struct {
        bit       rst, en;
        bit [1:0] cd;
        bit       fl, rdy;
        bit       ev;
        bit [1:0] ec;
        bit [5:0] er;
        bit [2:0] el;
        bit       eo;
    } vec_t;

    moore_code_rle #(.RUN_W(RW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .code_in   (code_in),
        .code_en   (code_en),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_run   (out_run),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, en, input bit [1:0] cd, input bit fl, rdy);
        bit       em;
        bit [7:0] rec;
        bit       pop;
        int       sz;
        em = 0;
        rec = '0;
        if (rst) begin
            m_open = 0; m_code = 0; m_cnt = 0; m_ovf = 0;
            mq.delete();
            return;
        end
        pop = rdy && (mq.size() > 0);
        if (!m_open) begin
            if (en) begin m_open = 1; m_code = cd; m_cnt = 1; end
        end else if (fl) begin
            em = 1; rec = {m_code[1:0], m_cnt[5:0]};
            if (en) begin m_code = cd; m_cnt = 1; end
            else m_open = 0;
        end else if (en) begin
            if (cd == m_code[1:0] && m_cnt < RMAX) begin
                m_cnt++;
            end else begin
                em = 1; rec = {m_code[1:0], m_cnt[5:0]};
                m_code = cd; m_cnt = 1;
            end
        end
        sz = mq.size();
        if (pop) void'(mq.pop_front());
        if (em) begin
            if (sz == DEPTH && !pop) m_ovf = 1;
            else mq.push_back(rec);
        end
    endtask

    task automatic model_check(input bit after_rst);
        chk("valid", out_valid, mq.size() > 0);
        chk("level", level, mq.size());
        chk("overflow", overflow, m_ovf);
        if (mq.size() > 0) begin
            chk("head_code", out_code, mq[0][7:6]);
            chk("head_run", out_run, mq[0][5:0]);
        end else if (after_rst) begin
            chk("rst_code", out_code, 0);
            chk("rst_run", out_run, 0);
        end
    endtask

    task automatic step(input bit rst, en, input bit [1:0] cd, input bit fl, rdy);
        reset = rst; code_en = en; code_in = cd; flush = fl; out_ready = rdy;
        if (!rst && rdy && out_valid) got.push_back({out_code, out_run});
        @(posedge clk);
        model_edge(rst, en, cd, fl, rdy);
        @(negedge clk);
        model_check(rst);
    endtask

    task automatic chk_got(input string nm, input bit [7:0] exp[$]);
        chk({nm, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk({nm, "_rec"}, got[i], exp[i]);
    endtask

    vec_t vt[8];

    initial begin
        bit [1:0] prev;
        bit [7:0] e[$];
        reset = 1; code_en = 0; code_in = 0; flush = 0; out_ready = 0;

        // Mixed codes: 01,10,10,10,11, flush, drain.
        vt[0] = '{1,0,2'b00,0,1, 0,2'b00,6'd0,3'd0,0};
        vt[1] = '{0,1,2'b01,0,1, 0,2'b00,6'd0,3'd0,0};
        vt[2] = '{0,1,2'b10,0,1, 1,2'b01,6'd1,3'd1,0};
        vt[3] = '{0,1,2'b10,0,1, 0,2'b00,6'd0,3'd0,0};
        vt[4] = '{0,1,2'b10,0,1, 0,2'b00,6'd0,3'd0,0};
        vt[5] = '{0,1,2'b11,0,1, 1,2'b10,6'd3,3'd1,0};
        vt[6] = '{0,0,2'b00,1,1, 1,2'b11,6'd1,3'd1,0};
        vt[7] = '{0,0,2'b00,0,1, 0,2'b00,6'd0,3'd0,0};
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(vt[i].rst, vt[i].en, vt[i].cd, vt[i].fl, vt[i].rdy);
            chk("tbl_valid", out_valid, vt[i].ev);
            chk("tbl_level", level, vt[i].el);
            chk("tbl_ovf", overflow, vt[i].eo);
            if (vt[i].ev || vt[i].rst) begin
                chk("tbl_code", out_code, vt[i].ec);
                chk("tbl_run", out_run, vt[i].er);
            end
        end

        // Saturation: 70 enabled 11s then flush.
        step(1, 0, 0, 0, 0);
        got.delete();
        for (int i = 0; i < 70; i++) step(0, 1, 2'b11, 0, 1);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        e = '{8'hFF, 8'hC7};
        chk_got("sat", e);

        // Overflow: five records into a four-deep FIFO with no consumer.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 2'(i & 1), 0, 0);
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        got.delete();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        e = '{8'h01, 8'h41, 8'h01, 8'h41};
        chk_got("ovf", e);
        chk("ovf_sticky", overflow, 1);

        // Full with simultaneous pop and emit.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'(i & 1), 0, 0);
        chk("fp_level_pre", level, 4);
        got.delete();
        step(0, 1, 2'b10, 0, 1);
        chk("fp_level", level, 4);
        chk("fp_ovf", overflow, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        e = '{8'h01, 8'h41, 8'h01, 8'h41, 8'h01};
        chk_got("fp", e);

        // Gaps, then flush colliding with code_en, then flush.
        step(1, 0, 0, 0, 0);
        got.delete();
        step(0, 1, 2'b10, 0, 1); step(0, 0, 0, 0, 1);
        step(0, 1, 2'b10, 0, 1); step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
        step(0, 1, 2'b10, 0, 1);
        step(0, 1, 2'b01, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        e = '{8'h83, 8'h41};
        chk_got("gap", e);
        chk("gap_level", level, 0);

        // Reset mid-operation with an open run of 5 and two queued records.
        step(1, 0, 0, 0, 0);
        step(0, 1, 2'b00, 0, 0); step(0, 1, 2'b01, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'b10, 0, 0);
        chk("mid_level", level, 2);
        step(1, 0, 0, 0, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_lvl0", level, 0);
        chk("mid_code", out_code, 0);
        chk("mid_run", out_run, 0);
        got.delete();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        chk("mid_none", got.size(), 0);

        // Random traffic with sticky codes so some runs saturate.
        step(1, 0, 0, 0, 0);
        prev = 0;
        for (int i = 0; i < 4000; i++) begin
            bit       en, fl, rdy, rst;
            bit [1:0] cd;
            cd  = ($urandom_range(0, 99) < 90) ? prev : 2'($urandom_range(0, 3));
            prev = cd;
            en  = $urandom_range(0, 99) < 75;
            fl  = $urandom_range(0, 99) < 4;
            rdy = $urandom_range(0, 99) < 55;
            rst = $urandom_range(0, 999) < 2;
            step(rst, en, cd, fl, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/moore_code_rle.md
# moore_code_rle

Run-length encoder for the 2-bit Moore state-machine output code stream. Sits directly downstream of the 4-state Moore sequencer and consumes its `data_out` code each enabled cycle. It compresses consecutive identical codes into {code, run} records and buffers them in a small FIFO. The FIFO drains over a valid/ready interface toward logging or host logic.

## Interface
- `RUN_W`, default 6: run counter width. Maximum run is RUN_MAX = 2^RUN_W-1.
- `DEPTH`, default 4: FIFO depth in records. Must be a power of 2, ≥2.
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `reset` input, 1 bit: reset is synchronous and active-high; one clock.
- `code_in` input, 2 bits: Moore code from the upstream sequencer.
- `code_en` input, 1 bit: `code_in` is sampled on this edge.
- `flush` input, 1 bit: close the open run and emit it.
- `out_valid` output, 1 bit: a FIFO head record is present.
- `out_ready` input, 1 bit: consumer accepts the head record this edge.
- `out_code` output, 2 bits: code field of the head record.
- `out_run` output, RUN_W bits: run length of the head record, range 1..RUN_MAX.
- `overflow` output, 1 bit: sticky flag; a record was dropped.
- `level` output, $clog2(DEPTH)+1 bits: current FIFO occupancy.

## Operation
- FSM states:
  - IDLE: no open run. Reset state.
  - RUN: `cur_code` and `run_cnt` hold the open run.
- IDLE:
  - `code_en`: load `cur_code`=`code_in`, `run_cnt`=1, go to RUN.
  - `flush` alone: no effect.
- RUN with `code_en`, no `flush`:
  - `code_in`==`cur_code` and `run_cnt`<RUN_MAX: `run_cnt`+1, no emit.
  - `code_in`==`cur_code` and `run_cnt`==RUN_MAX: emit {`cur_code`, RUN_MAX}, restart run at 1 with the same code.
  - `code_in`!=`cur_code`: emit {`cur_code`, `run_cnt`}, start new run {`code_in`, 1}.
- RUN with `flush`, no `code_en`: emit {`cur_code`, `run_cnt`}, go to IDLE.
- RUN with `flush` and `code_en` together:
  - Emit the open run, then start {`code_in`, 1} and stay in RUN.
  - `code_in` is never merged into the flushed run.
- Cycles with `code_en`=0 neither extend nor break a run.
- At most one emit per cycle.
- FIFO rules:
  - Push on emit. Pop when `out_valid`&&`out_ready`.
  - Push when full with no pop in the same cycle: the record is dropped and `overflow` is set.
  - Push when full with a simultaneous pop: accepted, `level` unchanged, no overflow.
  - Pop when empty: ignored.
  - Records leave in emission order. Pointers wrap modulo DEPTH.
- `overflow` clears only on `reset`.
- `run_cnt` never wraps; saturation forces an emit as described above.

## Timing
- Reset values:
  - state=IDLE, `run_cnt`=0, `cur_code`=0.
  - `out_valid`=0, `out_code`=0, `out_run`=0.
  - `overflow`=0, `level`=0.
- Reset mid-run discards the open run and all FIFO contents; no record is emitted.
- Emit latency: the trigger is sampled at edge N, the record is written at edge N, and `out_valid`/`level` reflect it from edge N onward, i.e. in the cycle after the trigger is presented.
- `out_code` and `out_run` are registered FIFO head data. They are stable while `out_valid`=1 and `out_ready`=0.
- Throughput: 1 record/cycle in and 1 record/cycle out.
- `level` counts FIFO entries only, not the open run.
- `out_valid` and `level` are registered; there is no combinational path from `out_ready` to outputs.

## Structure
- Package `moore_rle_pkg`:
  - `rle_state_t` enum {IDLE, RUN}.
  - `code_t` (2 bits).
  - Record width constant REC_W = 2+RUN_W, for packing {code, run}.
- Sub-module `moore_rle_fifo`:
  - Synchronous FIFO of REC_W × DEPTH.
  - Ports: push/pop, full/empty, `level`, registered head.
  - Owns the full+pop acceptance rule.
- Top level `moore_code_rle`: FSM, run counter, emit logic, sticky overflow flag.

## Test plan
- Mixed codes: `code_en` every cycle with codes 01,10,10,10,11, then `flush`, `out_ready`=1 → records (01,1), (10,3), (11,1), then `out_valid`=0, `level`=0.
- Saturation: 70 enabled 11s then `flush` (RUN_W=6) → records (11,63), (11,7).
- Overflow: `out_ready`=0, produce 5 records → `level`=4, `overflow`=1. Raising `out_ready` drains records 1–4 in order; the 5th is lost and `overflow` stays 1.
- Full with pop: FIFO full, `out_ready`=1, and an emit in the same cycle → no overflow, `level` stays 4, output order preserved.
- Gaps and flush collision: enabled 10s with idle gaps, then `flush`+`code_en`(01) together, then `flush` → records (10, n), (01,1), state IDLE.
- Reset mid-operation: assert `reset` with `run_cnt`=5 and `level`=2 → next cycle all outputs are zero and no record appears afterwards.
